// File: rtl/lzs_encode_pack.sv
// lzs_encode_pack: LZS token encoder with MSB-first bit packer.
//   Accepts literal/match tokens, encodes them as an LZS bit stream into an
//   ACC_W-bit accumulator and drains whole bytes to a downstream FIFO. A stream
//   ends with the end marker 110000000 followed by zero padding to a byte.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ce                         start enable (sampled in S_IDLE)
//   tok_valid / tok_ack        token handshake (tok_ack combinational)
//   tok_match, tok_lit, tok_off, tok_len, tok_last   token fields
//   fo_full                    downstream full, blocks byte output
//   out_data, out_valid        registered output byte, bit 7 first
//   out_done                   high while the stream is finished (S_DONE)
// Optional: define LZS_ENCODE_BYTECNT_EN to add out_cnt[31:0], a per-stream
//   count of output bytes.
module lzs_encode_pack #(
  parameter int ACC_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        tok_valid,
  output logic        tok_ack,
  input  logic        tok_match,
  input  logic [7:0]  tok_lit,
  input  logic [10:0] tok_off,
  input  logic [10:0] tok_len,
  input  logic        tok_last,
  input  logic        fo_full,
  output logic [7:0]  out_data,
  output logic        out_valid,
`ifdef LZS_ENCODE_BYTECNT_EN
  output logic [31:0] out_cnt,
`endif
  output logic        out_done
);

  localparam int CW = $clog2(ACC_W + 1);
  localparam logic [CW-1:0] EIGHT   = CW'(8);
  localparam logic [CW-1:0] LIM_TOK = CW'(ACC_W - 17);
  localparam logic [CW-1:0] LIM_NIB = CW'(ACC_W - 4);
  localparam logic [CW-1:0] LIM_END = CW'(ACC_W - 9);

  typedef enum logic [2:0] {S_IDLE, S_TOK, S_LENX, S_END, S_FLUSH, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_dr;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_dr;
  logic [10:0]     res_q, res_d;
  logic            last_q, last_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            drain, pad;
  // Appended code is left-aligned in a 17-bit field; app_n bits are valid.
  logic [16:0]     app_bits, mbits;
  logic [4:0]      app_n, mn, lcn;
  logic [3:0]      lc4;

  // Match code: offset field plus the first length code, left-aligned.
  always_comb begin
    lc4 = 4'hF;
    lcn = 5'd4;
    if (tok_len < 11'd5) begin
      lc4 = {tok_len[1:0] - 2'd2, 2'b00};   // 2..4 -> 00,01,10
      lcn = 5'd2;
    end else if (tok_len < 11'd8) begin
      lc4 = {2'b11, tok_len[1:0] - 2'd1};   // 5..7 -> 1100,1101,1110
    end
    if (tok_off < 11'd128) begin
      mbits = {2'b11, tok_off[6:0], lc4, 4'b0000};
      mn    = 5'd9 + lcn;
    end else begin
      mbits = {2'b10, tok_off, lc4};
      mn    = 5'd13 + lcn;
    end
  end

  always_comb begin
    // Byte drain happens first; appends see the post-drain fill level.
    drain       = (cnt_q >= EIGHT) && !fo_full;
    acc_dr      = drain ? (acc_q << 8) : acc_q;
    cnt_dr      = drain ? (cnt_q - EIGHT) : cnt_q;
    out_valid_d = drain;
    out_data_d  = drain ? acc_q[ACC_W-1 -: 8] : out_data_q;

    state_d  = state_q;
    res_d    = res_q;
    last_d   = last_q;
    app_bits = '0;
    app_n    = '0;
    tok_ack  = 1'b0;
    pad      = 1'b0;

    case (state_q)
      S_IDLE: if (ce) state_d = S_TOK;
      S_TOK: begin
        if (tok_valid && (cnt_dr <= LIM_TOK)) begin
          tok_ack = 1'b1;
          last_d  = tok_last;
          if (tok_match) begin
            app_bits = mbits;
            app_n    = mn;
          end else begin
            app_bits = {1'b0, tok_lit, 8'h00};
            app_n    = 5'd9;
          end
          if (tok_match && (tok_len >= 11'd8)) begin
            res_d   = tok_len - 11'd8;
            state_d = S_LENX;
          end else if (tok_last) begin
            state_d = S_END;
          end
        end
      end
      S_LENX: begin
        if (cnt_dr <= LIM_NIB) begin
          app_n = 5'd4;
          if (res_q >= 11'd15) begin
            app_bits = {4'hF, 13'b0};
            res_d    = res_q - 11'd15;
          end else begin
            app_bits = {res_q[3:0], 13'b0};
            res_d    = '0;
            state_d  = last_q ? S_END : S_TOK;
          end
        end
      end
      S_END: begin
        if (cnt_dr <= LIM_END) begin
          app_bits = {9'b110000000, 8'h00};
          app_n    = 5'd9;
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Pad only once the remainder is a partial byte; padding bits are
        // already zero below the valid region, so only the count moves.
        if (cnt_q == '0)                          state_d = S_DONE;
        else if ((cnt_dr < EIGHT) && (cnt_dr != '0)) pad = 1'b1;
      end
      S_DONE: if (!ce) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    acc_d = acc_dr | ({app_bits, {(ACC_W-17){1'b0}}} >> cnt_dr);
    cnt_d = pad ? EIGHT : (cnt_dr + CW'(app_n));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      last_q      <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_done  = (state_q == S_DONE);

`ifdef LZS_ENCODE_BYTECNT_EN
  logic [31:0] out_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          out_cnt_q <= '0;
    else if ((state_q == S_IDLE) && ce)  out_cnt_q <= '0;
    else if (out_valid_q)                out_cnt_q <= out_cnt_q + 32'd1;
  end
  assign out_cnt = out_cnt_q;
`endif

endmodule

// File: tb/tb_lzs_encode_pack.sv
// Bench for lzs_encode_pack: a bit-queue model of the LZS stream produces the
// expected bytes; every output byte is compared against it, and a few streams
// are also pinned to hand-computed byte values.
module tb_lzs_encode_pack;
  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, tok_valid = 1'b0;
  logic tok_match = 1'b0, tok_last = 1'b0, fo_full = 1'b0;
  logic [7:0]  tok_lit = '0;
  logic [10:0] tok_off = '0, tok_len = '0;
  logic tok_ack, out_valid, out_done;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  lzs_encode_pack #(.ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .tok_valid(tok_valid), .tok_ack(tok_ack),
    .tok_match(tok_match), .tok_lit(tok_lit), .tok_off(tok_off), .tok_len(tok_len),
    .tok_last(tok_last), .fo_full(fo_full), .out_data(out_data),
    .out_valid(out_valid), .out_done(out_done)
  );

  typedef struct {bit m; int lit; int off; int len; bit last;} tok_t;
  tok_t tq[$];
  bit   bq[$];
  int   exp_q[$], got_q[$], ref_q[$];
  int   chk_n = 0, pass_n = 0, stalls = 0, stalls_ref = 0;
  bit   full_at_edge = 1'b0, rand_full = 1'b0;

  function automatic void chk(bit ok, string name, int act, int exp);
    chk_n++;
    if (ok) pass_n++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic tok_t L(int v, bit last);
    tok_t t; t.m = 0; t.lit = v; t.off = 0; t.len = 0; t.last = last; return t;
  endfunction
  function automatic tok_t M(int off, int len, bit last);
    tok_t t; t.m = 1; t.lit = 0; t.off = off; t.len = len; t.last = last; return t;
  endfunction

  // Stream model: bits appended MSB-first, whole bytes moved to exp_q.
  function automatic void push_bits(int v, int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(bit'((v >> i) & 1));
    while (bq.size() >= 8) begin
      int b;
      b = 0;
      for (int k = 0; k < 8; k++) b = (b << 1) | int'(bq.pop_front());
      exp_q.push_back(b);
    end
  endfunction

  function automatic void model_tok(tok_t t);
    int r;
    if (!t.m) begin
      push_bits(0, 1); push_bits(t.lit, 8);
    end else begin
      push_bits(1, 1);
      if (t.off < 128) begin push_bits(1, 1); push_bits(t.off, 7); end
      else             begin push_bits(0, 1); push_bits(t.off, 11); end
      if (t.len <= 4)      push_bits(t.len - 2, 2);
      else if (t.len <= 7) push_bits(12 + t.len - 5, 4);
      else begin
        push_bits(15, 4);
        r = t.len - 8;
        while (r >= 15) begin push_bits(15, 4); r -= 15; end
        push_bits(r, 4);
      end
    end
    if (t.last) begin
      push_bits(384, 9);                       // 110000000
      while (bq.size() != 0) push_bits(0, 1);
    end
  endfunction

  // Output compare, every cycle.
  always @(posedge clk) full_at_edge = fo_full;
  always @(negedge clk) begin
    if (rst_n) begin
      if (full_at_edge) chk(!out_valid, "no_byte_when_full", int'(out_valid), 0);
      if (out_valid) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_byte", int'(out_data), -1);
        else begin
          int e;
          e = exp_q.pop_front();
          chk(int'(out_data) == e, "stream_byte", int'(out_data), e);
        end
        got_q.push_back(int'(out_data));
      end
    end
  end

  always @(posedge clk) if (rand_full) begin
    #1 fo_full = ($urandom_range(0, 3) == 0);
  end

  task automatic drive(tok_t t);
    tok_valid = 1'b1; tok_match = t.m; tok_lit = 8'(t.lit);
    tok_off = 11'(t.off); tok_len = 11'(t.len); tok_last = t.last;
  endtask

  task automatic wait_ack(output bit acked);
    acked = 1'b0;
    for (int c = 0; c < 400 && !acked; c++) begin
      @(negedge clk);
      if (tok_ack) acked = 1'b1; else stalls++;
    end
    if (!acked) chk(1'b0, "ack_timeout", 0, 1);
  endtask

  task automatic run_stream();
    bit acked, done;
    got_q.delete(); stalls = 0;
    ce = 1'b1; drive(tq[0]);
    @(negedge clk);
    chk(!tok_ack, "idle_no_ack", int'(tok_ack), 0);
    foreach (tq[i]) begin
      drive(tq[i]); model_tok(tq[i]);
      wait_ack(acked);
      @(posedge clk); #1;
    end
    tok_valid = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      done = out_done;
    end
    chk(done, "done_reached", int'(done), 1);
    chk(exp_q.size() == 0, "stream_complete", exp_q.size(), 0);
    ce = 1'b0;
    @(posedge clk); #1;
    chk(!out_done, "done_clears", int'(out_done), 0);
  endtask

  task automatic chk_bytes(input int e[$], input string name);
    chk(got_q.size() == e.size(), {name, "_count"}, got_q.size(), e.size());
    foreach (e[i]) if (i < got_q.size()) chk(got_q[i] == e[i], name, got_q[i], e[i]);
  endtask

  initial begin
    int e[$];
    bit acked;
    repeat (3) @(posedge clk); #1;
    chk(!out_valid, "rst_out_valid", int'(out_valid), 0);
    chk(out_data == 8'h00, "rst_out_data", int'(out_data), 0);
    chk(!out_done, "rst_out_done", int'(out_done), 0);
    chk(!tok_ack, "rst_tok_ack", int'(tok_ack), 0);
    rst_n = 1'b1;

    tq = '{L('h41, 1)}; run_stream();
    e = '{'h20, 'hE0, 'h00}; chk_bytes(e, "lit41");

    tq = '{M(5, 2, 1)}; run_stream();
    e = '{'hC2, 'h98, 'h00}; chk_bytes(e, "m5_2");

    tq = '{M(300, 8, 1)}; run_stream();
    e = '{'h89, 'h67, 'h86, 'h00}; chk_bytes(e, "len8");
    tq = '{M(300, 22, 1)}; run_stream();
    e = '{'h89, 'h67, 'hF6, 'h00}; chk_bytes(e, "len22");
    tq = '{M(300, 23, 1)}; run_stream();
    e = '{'h89, 'h67, 'hF8, 'h60, 'h00}; chk_bytes(e, "len23");

    // Back-to-back literals, then the same with a 20-cycle full window.
    tq.delete();
    for (int i = 0; i < 10; i++) tq.push_back(L(i * 23 + 7, i == 9));
    run_stream();
    ref_q = got_q; stalls_ref = stalls;
    fork
      begin
        repeat (4) @(posedge clk); #1 fo_full = 1'b1;
        repeat (20) @(posedge clk); #1 fo_full = 1'b0;
      end
    join_none
    run_stream();
    chk(stalls > stalls_ref, "full_stalls_ack", stalls, stalls_ref + 1);
    chk_bytes(ref_q, "full_same_stream");

    // Reset during the long length-nibble run of a len=300 match.
    got_q.delete();
    ce = 1'b1; tq = '{M(300, 300, 0)}; drive(tq[0]); model_tok(tq[0]);
    wait_ack(acked);
    @(posedge clk); #1 tok_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk(!out_valid, "midrst_out_valid", int'(out_valid), 0);
    chk(out_data == 8'h00, "midrst_out_data", int'(out_data), 0);
    chk(!out_done, "midrst_out_done", int'(out_done), 0);
    chk(!tok_ack, "midrst_tok_ack", int'(tok_ack), 0);
    exp_q.delete(); bq.delete(); ce = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    tq = '{L('h41, 1)}; run_stream();
    e = '{'h20, 'hE0, 'h00}; chk_bytes(e, "after_rst");

    // Random streams under random backpressure.
    rand_full = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tq.delete();
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 1) == 0) tq.push_back(L(int'($urandom_range(0, 255)), i == 11));
        else tq.push_back(M(($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 127))
                                                         : int'($urandom_range(128, 2047)),
                            ($urandom_range(0, 2) == 0) ? int'($urandom_range(8, 80))
                                                         : int'($urandom_range(2, 9)),
                            i == 11));
      end
      run_stream();
    end
    rand_full = 1'b0;
    @(posedge clk); #2 fo_full = 1'b0;

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule
